flow_route_sequencer: RTL and testbench

FLOW_ROUTE_SEQUENCER -- requirements
Module: flow_route_sequencer

---
 rtl/flow_route_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_flow_route_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/flow_route_sequencer.sv
// Valve-routing sequencer: LOAD -> MIX -> HEAT -> FILTER -> DRAIN, with abort and branch-rule rejection.
// Define FLOW_SEQ_FLUSH_EN to add a FLUSH phase (all downstream valves open) between DRAIN and IDLE.
module flow_route_sequencer #(
    parameter int LOAD_CYCLES = 8,
    parameter int MIX_CYCLES  = 16,
    parameter int HEAT_CYCLES = 32,
    parameter int FILT_CYCLES = 8,
    parameter int CNT_W       = 8
`ifdef FLOW_SEQ_FLUSH_EN
    , parameter int FLUSH_CYCLES = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       source_sel,
    input  logic [1:0] mixer_sel,
    input  logic [1:0] heater_sel,
    input  logic       filter_sel,
    output logic [1:0] src_valve,
    output logic [3:0] mixer_valve,
    output logic [3:0] heater_valve,
    output logic [1:0] filter_valve,
    output logic       out_valve,
    output logic [2:0] stage,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_MIX    = 3'd2,
        S_HEAT   = 3'd3,
        S_FILTER = 3'd4,
        S_DRAIN  = 3'd5,
        S_FLUSH  = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             src_sel_q, src_sel_d;
    logic [1:0]       mix_sel_q, mix_sel_d;
    logic [1:0]       heat_sel_q, heat_sel_d;
    logic             filt_sel_q, filt_sel_d;
    logic [1:0]       src_valve_q, src_valve_d;
    logic [3:0]       mixer_valve_q, mixer_valve_d;
    logic [3:0]       heater_valve_q, heater_valve_d;
    logic [1:0]       filter_valve_q, filter_valve_d;
    logic             out_valve_q, out_valve_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            src_sel_q      <= 1'b0;
            mix_sel_q      <= 2'd0;
            heat_sel_q     <= 2'd0;
            filt_sel_q     <= 1'b0;
            src_valve_q    <= 2'd0;
            mixer_valve_q  <= 4'd0;
            heater_valve_q <= 4'd0;
            filter_valve_q <= 2'd0;
            out_valve_q    <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            src_sel_q      <= src_sel_d;
            mix_sel_q      <= mix_sel_d;
            heat_sel_q     <= heat_sel_d;
            filt_sel_q     <= filt_sel_d;
            src_valve_q    <= src_valve_d;
            mixer_valve_q  <= mixer_valve_d;
            heater_valve_q <= heater_valve_d;
            filter_valve_q <= filter_valve_d;
            out_valve_q    <= out_valve_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    // Next state, counter, select capture and status pulses.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src_sel_d  = src_sel_q;
        mix_sel_d  = mix_sel_q;
        heat_sel_d = heat_sel_q;
        filt_sel_d = filt_sel_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Mixer1/2 plumb only to Heater1/2, Mixer3/4 only to Heater3/4.
                    if (mixer_sel[1] != heater_sel[1]) begin
                        error_d = 1'b1;
                    end else begin
                        src_sel_d  = source_sel;
                        mix_sel_d  = mixer_sel;
                        heat_sel_d = heater_sel;
                        filt_sel_d = filter_sel;
                        state_d    = S_LOAD;
                        cnt_d      = CNT_W'(LOAD_CYCLES - 1);
                    end
                end
            end
            default: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    error_d = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    case (state_q)
                        S_LOAD: begin
                            state_d = S_MIX;
                            cnt_d   = CNT_W'(MIX_CYCLES - 1);
                        end
                        S_MIX: begin
                            state_d = S_HEAT;
                            cnt_d   = CNT_W'(HEAT_CYCLES - 1);
                        end
                        S_HEAT: begin
                            state_d = S_FILTER;
                            cnt_d   = CNT_W'(FILT_CYCLES - 1);
                        end
                        S_FILTER: begin
                            state_d = S_DRAIN;
                            cnt_d   = CNT_W'(FILT_CYCLES - 1);
                        end
`ifdef FLOW_SEQ_FLUSH_EN
                        S_DRAIN: begin
                            state_d = S_FLUSH;
                            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                        end
`endif
                        default: begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    // Valves are decoded from the upcoming state so they switch on the same edge as stage.
    always_comb begin
        src_valve_d    = 2'd0;
        mixer_valve_d  = 4'd0;
        heater_valve_d = 4'd0;
        filter_valve_d = 2'd0;
        out_valve_d    = 1'b0;
        case (state_d)
            S_LOAD: begin
                src_valve_d   = 2'b01 << src_sel_d;
                mixer_valve_d = 4'b0001 << mix_sel_d;
            end
            S_MIX: begin
                mixer_valve_d = 4'b0001 << mix_sel_d;
            end
            S_HEAT: begin
                mixer_valve_d  = 4'b0001 << mix_sel_d;
                heater_valve_d = 4'b0001 << heat_sel_d;
            end
            S_FILTER: begin
                heater_valve_d = 4'b0001 << heat_sel_d;
                filter_valve_d = 2'b01 << filt_sel_d;
            end
            S_DRAIN: begin
                filter_valve_d = 2'b01 << filt_sel_d;
                out_valve_d    = 1'b1;
            end
            S_FLUSH: begin
                mixer_valve_d  = 4'b1111;
                heater_valve_d = 4'b1111;
                filter_valve_d = 2'b11;
                out_valve_d    = 1'b1;
            end
            default: ;
        endcase
    end

    assign src_valve    = src_valve_q;
    assign mixer_valve  = mixer_valve_q;
    assign heater_valve = heater_valve_q;
    assign filter_valve = filter_valve_q;
    assign out_valve    = out_valve_q;
    assign stage        = state_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_flow_route_sequencer.sv
// Directed bench for flow_route_sequencer: full runs, branch rejection, abort, async reset, back-to-back runs.
module tb_flow_route_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       source_sel;
    logic [1:0] mixer_sel;
    logic [1:0] heater_sel;
    logic       filter_sel;
    logic [1:0] src_valve;
    logic [3:0] mixer_valve;
    logic [3:0] heater_valve;
    logic [1:0] filter_valve;
    logic       out_valve;
    logic [2:0] stage;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;

`ifdef FLOW_SEQ_FLUSH_EN
    localparam int FLUSH_N = 16;
`else
    localparam int FLUSH_N = 0;
`endif
    // Edge count from the start-sampling edge (1) through the done edge.
    localparam int RUN_LEN = 73 + FLUSH_N;

    flow_route_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .source_sel   (source_sel),
        .mixer_sel    (mixer_sel),
        .heater_sel   (heater_sel),
        .filter_sel   (filter_sel),
        .src_valve    (src_valve),
        .mixer_valve  (mixer_valve),
        .heater_valve (heater_valve),
        .filter_valve (filter_valve),
        .out_valve    (out_valve),
        .stage        (stage),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_stage(input int k);
        if (k <= 8)                 return 1;
        else if (k <= 24)           return 2;
        else if (k <= 56)           return 3;
        else if (k <= 64)           return 4;
        else if (k <= 72)           return 5;
        else if (k <= 72 + FLUSH_N) return 6;
        else                        return 0;
    endfunction

    // Packed {src[1:0], mixer[3:0], heater[3:0], filter[1:0], out}.
    function automatic logic [12:0] exp_valves(input int st, input logic s, input logic [1:0] m,
                                               input logic [1:0] h, input logic f);
        logic [1:0] sv;
        logic [3:0] mv;
        logic [3:0] hv;
        logic [1:0] fv;
        logic       ov;
        sv = 2'd0; mv = 4'd0; hv = 4'd0; fv = 2'd0; ov = 1'b0;
        case (st)
            1: begin sv[s] = 1'b1; mv[m] = 1'b1; end
            2: mv[m] = 1'b1;
            3: begin mv[m] = 1'b1; hv[h] = 1'b1; end
            4: begin hv[h] = 1'b1; fv[f] = 1'b1; end
            5: begin fv[f] = 1'b1; ov = 1'b1; end
            6: begin mv = 4'hf; hv = 4'hf; fv = 2'h3; ov = 1'b1; end
            default: ;
        endcase
        return {sv, mv, hv, fv, ov};
    endfunction

    function automatic logic [12:0] dut_valves();
        return {src_valve, mixer_valve, heater_valve, filter_valve, out_valve};
    endfunction

    // Start a run with the given selects and check every cycle for ncyc edges.
    // Selects are scrambled mid-run; the captured copies must keep driving the valves.
    task automatic do_run(input string tag, input logic s, input logic [1:0] m, input logic [1:0] h,
                          input logic f, input bit hold_start, input int ncyc);
        int es;
        source_sel = s; mixer_sel = m; heater_sel = h; filter_sel = f;
        start = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            if (!hold_start) start = 1'b0;
            if (k < ncyc) begin
                source_sel = ~s; mixer_sel = ~m; heater_sel = h ^ 2'b01; filter_sel = ~f;
            end
            es = exp_stage(k);
            check($sformatf("%s stage k=%0d", tag, k), 32'(stage), 32'(es));
            check($sformatf("%s valves k=%0d", tag, k), 32'(dut_valves()), 32'(exp_valves(es, s, m, h, f)));
            check($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'(es != 0));
            check($sformatf("%s done k=%0d", tag, k), 32'(done), 32'(k == RUN_LEN));
            check($sformatf("%s error k=%0d", tag, k), 32'(error), 32'd0);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_err);
        check({tag, " stage"}, 32'(stage), 32'd0);
        check({tag, " valves"}, 32'(dut_valves()), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " error"}, 32'(error), 32'(exp_err));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        source_sel = 1'b0; mixer_sel = 2'd0; heater_sel = 2'd0; filter_sel = 1'b0;
        tick(); tick();
        check_idle("reset", 1'b0);
        rst = 1'b0;

        // Reference run: Source2, Mixer3, Heater4, Filter1.
        do_run("run_a", 1'b1, 2'd2, 2'd3, 1'b0, 1'b0, RUN_LEN);
        tick();
        check_idle("after_run_a", 1'b0);

        // Branch-rule violations are rejected in IDLE with a single error pulse.
        source_sel = 1'b0; mixer_sel = 2'd0; heater_sel = 2'd2; filter_sel = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check_idle("bad_branch_0_2", 1'b1);
        tick();
        check_idle("bad_branch_clear", 1'b0);
        mixer_sel = 2'd3; heater_sel = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check_idle("bad_branch_3_1", 1'b1);
        tick();

        // Abort in HEAT.
        do_run("abort_heat", 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 30);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_heat", 1'b1);
        tick();
        check_idle("abort_heat_clear", 1'b0);

        // Abort coinciding with the last DRAIN count: abort wins, no done.
        do_run("abort_last", 1'b1, 2'd3, 2'd2, 1'b1, 1'b0, 72);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_last", 1'b1);

        // Abort while idle has no effect.
        abort = 1'b1;
        tick();
        check_idle("abort_idle", 1'b0);
        abort = 1'b0;
        tick();

        // Asynchronous reset mid-MIX clears outputs before the next edge.
        do_run("rst_mix", 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 12);
        #3;
        rst = 1'b1;
        #1;
        check_idle("rst_async", 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_run("after_rst", 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, RUN_LEN);
        tick();

        // start held high: the next run begins on the edge after done.
        do_run("held_1", 1'b1, 2'd1, 2'd1, 1'b0, 1'b1, RUN_LEN);
        do_run("held_2", 1'b0, 2'd2, 2'd2, 1'b1, 1'b0, RUN_LEN);
        tick();
        check_idle("final", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
